dmem_responder: RTL and testbench

- Data-memory responder on the far side of the pipeline's memory-access (MA) stage.
- The MA stage initiates load/store requests; this block accepts them, waits a configurable latency, performs the word access with byte enables, and returns read data or an error.
- It also drives a stall line that the hazard logic uses to hold PC, IF/ID and ID/EX while an access is outstanding.

---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int BYTE_W              = 8;
    localparam int NUM_LANES           = 4;
    localparam int WORD_W              = BYTE_W * NUM_LANES;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 2;

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables and a registered read port.
// Only the read register is reset; the array contents survive reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int  DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [AW-1:0]        idx_i,
    input  logic [WORD_W-1:0]    wdata_i,
    input  logic                 rd_en_i,
    input  logic                 clr_i,
    output logic [WORD_W-1:0]    rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read register holds until the next read or clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder behind the MA stage: accepts one request, waits LATENCY
// cycles, performs the word access and returns a one-cycle response strobe.
//
//   state | meaning
//   IDLE  | ready for a request; accept captures the request and loads the counter
//   WAIT  | counting down the access latency; pipeline held
//   RESP  | resp_valid high for one cycle, array accessed on the edge entering it
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [WORD_W-1:0]    req_wdata_i,
    input  logic [NUM_LANES-1:0] req_be_i,
    output logic                 req_ready_o,
    output logic                 resp_valid_o,
    output logic [WORD_W-1:0]    resp_rdata_o,
    output logic                 resp_err_o,
    output logic                 mem_stall_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of 2 in 16..4096");
    end

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cap_we_q;
    logic [31:0]          cap_addr_q;
    logic [WORD_W-1:0]    cap_wdata_q;
    logic [NUM_LANES-1:0] cap_be_q;
    logic                 ready_q;
    logic                 resp_valid_q;
    logic                 err_q;

    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [WORD_W-1:0]    acc_wdata;
    logic [NUM_LANES-1:0] acc_be;
    logic                 err_d;
    logic                 enter_resp;
    logic [WORD_W-1:0]    arr_rdata;

    // With LATENCY==1 the access edge is the accept edge, so use the live request.
    always_comb begin
        acc_we    = cap_we_q;
        acc_addr  = cap_addr_q;
        acc_wdata = cap_wdata_q;
        acc_be    = cap_be_q;
        if (state_q == ST_IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end
    end

    assign err_d = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));

    assign enter_resp = ((state_q == ST_IDLE) && req_valid_i && (LATENCY == 1)) ||
                        ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_we_q     <= 1'b0;
            cap_addr_q   <= '0;
            cap_wdata_q  <= '0;
            cap_be_q     <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        cap_we_q    <= req_we_i;
                        cap_addr_q  <= req_addr_i;
                        cap_wdata_q <= req_wdata_i;
                        cap_be_q    <= req_be_i;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        ready_q     <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= err_d;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (enter_resp) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= err_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (enter_resp && acc_we && !err_d),
        .be_i    (acc_be),
        .idx_i   (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .rd_en_i (enter_resp && !acc_we && !err_d),
        .clr_i   (enter_resp && (acc_we || err_d)),
        .rdata_o (arr_rdata)
    );

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = arr_rdata;
    assign resp_err_o   = err_q;
    assign mem_stall_o  = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 1 and 5.
module tb_dmem_responder;

    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 1, 5};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        req_ready [NI];
    logic        resp_valid[NI];
    logic [31:0] resp_rdata[NI];
    logic        resp_err  [NI];
    logic        mem_stall [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY    (LATS[g])
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_be_i    (req_be[g]),
            .req_ready_o (req_ready[g]),
            .resp_valid_o(resp_valid[g]),
            .resp_rdata_o(resp_rdata[g]),
            .resp_err_o  (resp_err[g]),
            .mem_stall_o (mem_stall[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int  cyc;
        bit  got;
        @(posedge clk); #1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(req_ready[d]), 32'd1);
        chk({tag, "_stall_req"}, 32'(mem_stall[d]), 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~addr;
        req_wdata[d] = ~wdata;
        req_be[d]    = ~be;
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (resp_valid[d]) begin
                got = 1'b1;
            end else begin
                chk({tag, "_stall_wait"}, 32'(mem_stall[d]), 32'd1);
                chk({tag, "_ready_wait"}, 32'(req_ready[d]), 32'd0);
            end
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LATS[d]));
        chk({tag, "_ready_resp"}, 32'(req_ready[d]), 32'd0);
        chk({tag, "_stall_resp"}, 32'(mem_stall[d]), 32'd0);
        chk({tag, "_rdata"}, resp_rdata[d], exp_rdata);
        chk({tag, "_err"}, 32'(resp_err[d]), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 32'(resp_valid[d]), 32'd0);
        chk({tag, "_rdata_hold"}, resp_rdata[d], exp_rdata);
        chk({tag, "_err_hold"}, 32'(resp_err[d]), 32'(exp_err));
        chk({tag, "_ready_back"}, 32'(req_ready[d]), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        int          n_acc, n_resp, n_extra;
        int          acc_cyc [3];
        int          resp_cyc[3];
        logic [31:0] b2b_addr[3];
        logic [31:0] b2b_exp [3];

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h40,  32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h40,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h01020304, 1'b0};
        vecs[12] = '{1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1};
        vecs[15] = '{1'b1, 32'h30,  32'h00000000, 4'hF, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 32'h30,  32'h0,        4'h0, 32'h0,        1'b0};

        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
        end

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_rdata", resp_rdata[i], 32'd0);
            chk("rst_err", 32'(resp_err[i]), 32'd0);
            chk("rst_stall", 32'(mem_stall[i]), 32'd0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            do_req(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be,
                   vecs[v].exp_rdata, vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        do_req(1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, "lat1_st");
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, "lat1_ld");
        do_req(1, 1'b0, 32'h1, 32'h0, 4'h0, 32'h0, 1'b1, "lat1_err");
        do_req(2, 1'b1, 32'h8, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0, "lat5_st");
        do_req(2, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h8, 32'h0, 1'b0, "lat5_part");
        do_req(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'hFF0F0F0F, 1'b0, "lat5_ld");

        // Back-to-back loads with req_valid held high throughout.
        b2b_addr = '{32'h10, 32'h20, 32'h0};
        b2b_exp  = '{32'hDEADBEEF, 32'h11BB33DD, 32'hCAFEF00D};
        n_acc = 0;
        n_resp = 0;
        @(posedge clk); #1;
        req_we[0]    = 1'b0;
        req_addr[0]  = b2b_addr[0];
        req_valid[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && n_resp < 3; cyc++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                resp_cyc[n_resp] = cyc;
                chk($sformatf("b2b_rdata%0d", n_resp), resp_rdata[0], b2b_exp[n_resp]);
                n_resp++;
            end
            if (req_ready[0] && req_valid[0]) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < 3) req_addr[0] = b2b_addr[n_acc];
                else           req_valid[0] = 1'b0;
            end
        end
        chk("b2b_nacc", 32'(n_acc), 32'd3);
        chk("b2b_nresp", 32'(n_resp), 32'd3);
        if (n_acc == 3 && n_resp == 3) begin
            chk("b2b_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_lat%0d", i), 32'(resp_cyc[i] - acc_cyc[i]), 32'd2);
        end
        n_extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid[0]) n_extra++;
        end
        chk("b2b_extra_pulses", 32'(n_extra), 32'd0);

        // Reset during WAIT of a store: store is dropped, outputs clear at once.
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "pre_rst_ld");
        @(posedge clk); #1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_in_wait", 32'(mem_stall[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst_valid", 32'(resp_valid[0]), 32'd0);
        chk("midrst_stall", 32'(mem_stall[0]), 32'd0);
        chk("midrst_rdata", resp_rdata[0], 32'd0);
        chk("midrst_err", 32'(resp_err[0]), 32'd0);
        n_extra = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid[0]) n_extra++;
        end
        chk("midrst_no_resp", 32'(n_extra), 32'd0);
        rst_n = 1'b1;
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, "post_rst_ld");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
